// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd_seq
// Description : Knight's-tour command sequencer. Passes UART commands through
//               while idle and turns each one-hot knight move into two legs.
// Revision    : 1.0 - initial release
// ============================================================================
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24,
  parameter int X_FIRST   = 1,
  localparam int IDX_W    = $clog2(NUM_MOVES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic             abort,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_A = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_MOVES - 1);
  localparam logic             LEG_A_HORIZ = (X_FIRST != 0);
  localparam logic [3:0]       OPC_A       = 4'h2;
  localparam logic [3:0]       OPC_B       = 4'h3;
  localparam logic [7:0]       RESP_OK     = 8'h5A;
  localparam logic [7:0]       RESP_DONE   = 8'hA5;
  localparam logic [7:0]       RESP_ERR    = 8'hE5;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
  logic [7:0]       move_q, move_d;
  logic [15:0]      tour_cmd_q, tour_cmd_d;
  logic             tour_rdy_q, tour_rdy_d;
  logic [7:0]       resp_q, resp_d;

  // Sign and |component|==2 are read straight off the one-hot move bits.
  function automatic logic [15:0] build_leg(input logic [7:0] mv,
                                            input logic       horiz,
                                            input logic [3:0] opc);
    logic       pos;
    logic       two;
    logic [7:0] heading;
    if (horiz) begin
      pos     = mv[1] | mv[2] | mv[3] | mv[5];
      two     = mv[2] | mv[3] | mv[6] | mv[7];
      heading = pos ? 8'hBF : 8'h3F;
    end else begin
      pos     = mv[0] | mv[1] | mv[2] | mv[7];
      two     = mv[0] | mv[1] | mv[4] | mv[5];
      heading = pos ? 8'h00 : 8'h7F;
    end
    return {opc, heading, (two ? 4'd2 : 4'd1)};
  endfunction

  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    move_d     = move_q;
    tour_cmd_d = tour_cmd_q;
    tour_rdy_d = tour_rdy_q;
    resp_d     = resp_q;

    // Clear first so that a new issue later in this block overrides it.
    if (clr_cmd_rdy) tour_rdy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_tour) begin
          if ($onehot(move)) begin
            mv_indx_d  = '0;
            move_d     = move;
            tour_cmd_d = build_leg(move, LEG_A_HORIZ, OPC_A);
            tour_rdy_d = 1'b1;
            resp_d     = RESP_OK;
            state_d    = WAIT_A;
          end else begin
            resp_d = RESP_ERR;
          end
        end
      end
      WAIT_A: begin
        if (abort) begin
          tour_rdy_d = 1'b0;
          resp_d     = RESP_ERR;
          state_d    = IDLE;
        end else if (send_resp) begin
          tour_cmd_d = build_leg(move_q, !LEG_A_HORIZ, OPC_B);
          tour_rdy_d = 1'b1;
          state_d    = WAIT_B;
        end
      end
      WAIT_B: begin
        if (abort) begin
          tour_rdy_d = 1'b0;
          resp_d     = RESP_ERR;
          state_d    = IDLE;
        end else if (send_resp) begin
          if (mv_indx_q == LAST_IDX) begin
            tour_rdy_d = 1'b0;
            resp_d     = RESP_DONE;
            state_d    = IDLE;
          end else if (!$onehot(move)) begin
            tour_rdy_d = 1'b0;
            resp_d     = RESP_ERR;
            state_d    = IDLE;
          end else begin
            mv_indx_d  = mv_indx_q + IDX_W'(1);
            move_d     = move;
            tour_cmd_d = build_leg(move, LEG_A_HORIZ, OPC_A);
            tour_rdy_d = 1'b1;
            state_d    = WAIT_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mv_indx_q  <= '0;
      move_q     <= '0;
      tour_cmd_q <= 16'h0000;
      tour_rdy_q <= 1'b0;
      resp_q     <= RESP_DONE;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      move_q     <= move_d;
      tour_cmd_q <= tour_cmd_d;
      tour_rdy_q <= tour_rdy_d;
      resp_q     <= resp_d;
    end
  end

  assign tour_busy = (state_q != IDLE);
  assign cmd       = tour_busy ? tour_cmd_q : cmd_UART;
  assign cmd_rdy   = tour_busy ? tour_rdy_q : cmd_rdy_UART;
  assign resp      = resp_q;
  assign mv_indx   = mv_indx_q;

endmodule
`default_nettype wire

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Parametrised knight's-tour command sequencer, successor to the fixed 24-move tour command block. It sits between the UART command receiver and the command processor. While idle it passes UART commands straight through. After `start_tour` it owns the command path and converts each one-hot knight move into two movement commands, with configurable tour length, configurable leg order, move legality checking and a mid-tour abort.

## Interface
- `NUM_MOVES`, 24: number of moves in a tour; legal range 2..32.
- `X_FIRST`, 1: 1 = horizontal leg issued first, vertical second; 0 = vertical first, horizontal second.
- `IDX_W`, $clog2(NUM_MOVES): width of `mv_indx`; derived, not overridden.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_tour`  in  1  pulse; begins a tour (ignored unless idle).
- `abort`  in  1  pulse; terminates a tour in progress.
- `move`  in  8  one-hot move for the current `mv_indx`.
- `mv_indx`  out  IDX_W  index of the move being executed.
- `cmd_UART`  in  16  command from UART.
- `cmd_rdy_UART`  in  1  UART command valid.
- `cmd`  out  16  command to the command processor.
- `cmd_rdy`  out  1  command valid.
- `clr_cmd_rdy`  in  1  consumer has taken `cmd`.
- `send_resp`  in  1  pulse; the previous command has completed.
- `resp`  out  8  response byte.
- `tour_busy`  out  1  high while the sequencer owns the command path.

## Operation
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
- Leg A uses opcode 0x2 (move). Leg B uses opcode 0x3 (move with fanfare).
- Headings: N 0x00, W 0x3F, S 0x7F, E 0xBF.
- Magnitudes: a ±2 component moves 2 squares; a ±1 component moves 1 square.
- Move bits as (dx,dy):
  - bit0 (-1,+2), bit1 (+1,+2)
  - bit2 (+2,+1), bit3 (+2,-1)
  - bit4 (-1,-2), bit5 (+1,-2)
  - bit6 (-2,-1), bit7 (-2,+1)
- States:
  - IDLE: `cmd`=`cmd_UART` and `cmd_rdy`=`cmd_rdy_UART`, both combinational; `tour_busy`=0.
  - WAIT_A and WAIT_B: outputs come from the internal `tour_cmd` and `tour_rdy` registers; `tour_busy`=1.
- IDLE & `start_tour`:
  - If `move` is not exactly one-hot: stay in IDLE, `resp`<=0xE5.
  - Otherwise: `mv_indx`<=0, latch `move`, `tour_cmd`<=leg A, `tour_rdy`<=1, `resp`<=0x5A, go to WAIT_A.
- WAIT_A & `send_resp`: `tour_cmd`<=leg B, built from the latched move, so `move` may change after leg A is issued. `tour_rdy`<=1, go to WAIT_B.
- WAIT_B & `send_resp`:
  - If `mv_indx`==NUM_MOVES-1: `resp`<=0xA5, `tour_rdy`<=0, go to IDLE. `mv_indx` holds its value.
  - Else if the new `move` is illegal: `resp`<=0xE5, go to IDLE.
  - Else: `mv_indx`<=`mv_indx`+1, latch `move`, issue leg A, go to WAIT_A.
- `clr_cmd_rdy` clears `tour_rdy`. If it coincides with a new issue, set wins.
- `abort` in WAIT_A or WAIT_B: `tour_rdy`<=0, `resp`<=0xE5, go to IDLE. `abort` in IDLE is ignored.
- `start_tour` outside IDLE is ignored.
- `abort` and `send_resp` in the same cycle: abort wins.

## Timing
- Reset values: state IDLE, `mv_indx` 0, `tour_cmd` 0x0000, `tour_rdy` 0, `resp` 0xA5, `tour_busy` 0.
- Reset asserted mid-tour returns to IDLE immediately; UART pass-through is restored combinationally.
- Latency from `start_tour` to `cmd_rdy`: 1 cycle; `cmd_rdy` is high after the edge that samples `start_tour`.
- Latency from `send_resp` to the next `cmd_rdy` or to the `resp` update: 1 cycle.
- `resp` holds until the next write.
- `cmd` is stable while `cmd_rdy` is high.
- A full tour issues exactly 2×NUM_MOVES commands.

## Test plan
- Reset, `cmd_UART`=0x3FAE, `cmd_rdy_UART`=1 -> `cmd`=0x3FAE, `cmd_rdy`=1, `resp`=0xA5, `tour_busy`=0.
- X_FIRST=1, `move`=0x01, `start_tour` -> after 1 cycle `cmd`=0x23F1, `cmd_rdy`=1, `mv_indx`=0; `clr_cmd_rdy` then `send_resp` -> `cmd`=0x3002. Then `move`=0x02 -> 0x2BF1, then 0x3002, `mv_indx`=1, `resp`=0x5A. Then `move`=0x10 -> 0x23F1, then 0x37F2.
- X_FIRST=0, NUM_MOVES=4, `move`=0x04 -> leg A 0x2001 (N 1), leg B 0x3BF2 (E 2).
- NUM_MOVES=4: run 8 `send_resp` cycles -> `mv_indx` 0..3, `resp`=0xA5 one cycle after the final `send_resp`, `cmd` returns to `cmd_UART`.
- `abort` during WAIT_B at `mv_indx`=2 -> `tour_busy`=0 and `resp`=0xE5 next cycle. A later `start_tour` restarts at `mv_indx`=0. Also: `start_tour` with `move`=0x03 -> no `cmd_rdy`, `resp`=0xE5.
- `clr_cmd_rdy` coincident with `send_resp` in WAIT_A -> `cmd_rdy`=1 with the leg B command. `rst` asserted mid-tour -> all outputs at reset values without waiting for a clock edge.
